// File: rtl/trojan_mon_pkg.sv
// Shared types and constants for the trigger-protocol monitor.
// The state encoding and alarm codes are visible to any block that decodes alarm_code.
package trojan_mon_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    EXT   = 2'd1,
    QUIET = 2'd2
  } state_e;

  localparam logic [1:0] CODE_NONE         = 2'd0;
  localparam logic [1:0] CODE_MISS_ARM     = 2'd1;
  localparam logic [1:0] CODE_EXT_MISMATCH = 2'd2;
  localparam logic [1:0] CODE_SPURIOUS     = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trojan_trigger_monitor.sv
// Passive checker for the arm/extend/quiet trigger protocol on Tj_Trig.
// Records the first violation, a legal extension, pattern hits and the longest high run.
//
// state | meaning
// ARM   | cycle 0 after reset: Tj_Trig must be high, capture pattern match
// EXT   | cycle 1: Tj_Trig must equal the match captured in ARM
// QUIET | cycle 2 onward: Tj_Trig must stay low
module trojan_trigger_monitor
  import trojan_mon_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] PATTERN = {DATA_W{1'b1}},
  parameter int                CNT_W   = 16,
  parameter int                RUN_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] desIn,
  input  logic              Tj_Trig,
  output logic              alarm,
  output logic [1:0]        alarm_code,
  output logic              fired,
  output logic [CNT_W-1:0]  hit_count,
  output logic [RUN_W-1:0]  max_run
);

  state_e           state_q, state_d;
  logic             match_q, match_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       code_q, code_d;
  logic             fired_q, fired_d;
  logic [RUN_W-1:0] max_q, max_d;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             pat_hit;
  logic             viol;
  logic [1:0]       viol_code;

  assign pat_hit = (desIn == PATTERN);

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (pat_hit),
    .cnt_o (hit_count)
  );

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~Tj_Trig),
    .inc_i (Tj_Trig),
    .cnt_o (run_cnt)
  );

  // Value the run counter takes on this edge when the line is high.
  assign run_next = (run_cnt == {RUN_W{1'b1}}) ? run_cnt : run_cnt + 1'b1;

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    fired_d   = fired_q;
    viol      = 1'b0;
    viol_code = CODE_NONE;
    case (state_q)
      ARM: begin
        match_d = pat_hit;
        if (!Tj_Trig) begin
          viol      = 1'b1;
          viol_code = CODE_MISS_ARM;
        end
        state_d = EXT;
      end
      EXT: begin
        if (Tj_Trig != match_q) begin
          viol      = 1'b1;
          viol_code = CODE_EXT_MISMATCH;
        end
        if (Tj_Trig && match_q) begin
          fired_d = 1'b1;
        end
        state_d = QUIET;
      end
      QUIET: begin
        if (Tj_Trig) begin
          viol      = 1'b1;
          viol_code = CODE_SPURIOUS;
        end
      end
      default: state_d = QUIET;
    endcase
  end

  // Only the first violation is latched; later ones leave the code alone.
  always_comb begin
    alarm_d = alarm_q;
    code_d  = code_q;
    if (viol && !alarm_q) begin
      alarm_d = 1'b1;
      code_d  = viol_code;
    end
  end

  always_comb begin
    max_d = max_q;
    if (Tj_Trig && (run_next > max_q)) begin
      max_d = run_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM;
      match_q <= 1'b0;
      alarm_q <= 1'b0;
      code_q  <= CODE_NONE;
      fired_q <= 1'b0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      alarm_q <= alarm_d;
      code_q  <= code_d;
      fired_q <= fired_d;
      max_q   <= max_d;
    end
  end

  assign alarm      = alarm_q;
  assign alarm_code = code_q;
  assign fired      = fired_q;
  assign max_run    = max_q;

endmodule

// File: tb/tb_trojan_trigger_monitor.sv
// Directed plus randomized bench for trojan_trigger_monitor against a cycle-indexed protocol model.
module tb_trojan_trigger_monitor;

  localparam logic [63:0] PAT     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          HIT_MAX = 65535;
  localparam int          RUN_MAX = 15;

  logic        clk;
  logic        rst;
  logic [63:0] desIn;
  logic        Tj_Trig;
  logic        alarm;
  logic [1:0]  alarm_code;
  logic        fired;
  logic [15:0] hit_count;
  logic [3:0]  max_run;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index since reset plus the protocol's expected results.
  int   m_cyc;
  bit   m_match;
  bit   e_alarm;
  int   e_code;
  bit   e_fired;
  int   e_hits;
  int   e_run;
  int   e_max;

  trojan_trigger_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .desIn      (desIn),
    .Tj_Trig    (Tj_Trig),
    .alarm      (alarm),
    .alarm_code (alarm_code),
    .fired      (fired),
    .hit_count  (hit_count),
    .max_run    (max_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model(input logic [63:0] d, input bit tj, input bit r);
    bit req;
    if (r) begin
      m_cyc = 0; m_match = 0; e_alarm = 0; e_code = 0;
      e_fired = 0; e_hits = 0; e_run = 0; e_max = 0;
      return;
    end
    req = (m_cyc == 0) ? 1'b1 : (m_cyc == 1) ? m_match : 1'b0;
    if (m_cyc == 0) m_match = (d == PAT);
    if (tj != req && !e_alarm) begin
      e_alarm = 1;
      e_code  = (m_cyc == 0) ? 1 : (m_cyc == 1) ? 2 : 3;
    end
    if (m_cyc == 1 && tj && m_match) e_fired = 1;
    if (d == PAT && e_hits < HIT_MAX) e_hits++;
    e_run = tj ? ((e_run < RUN_MAX) ? e_run + 1 : RUN_MAX) : 0;
    if (e_run > e_max) e_max = e_run;
    if (m_cyc < 2) m_cyc++;
  endtask

  task automatic step(input logic [63:0] d, input bit tj, input bit r);
    @(negedge clk);
    rst = r; desIn = d; Tj_Trig = tj;
    @(posedge clk);
    model(d, tj, r);
    #1;
    chk("alarm", int'(alarm), int'(e_alarm));
    chk("alarm_code", int'(alarm_code), e_code);
    chk("fired", int'(fired), int'(e_fired));
    chk("hit_count", int'(hit_count), e_hits);
    chk("max_run", int'(max_run), e_max);
  endtask

  task automatic do_reset();
    step(64'd0, 1'b1, 1'b1);
    step(PAT, 1'b1, 1'b1);
  endtask

  initial begin
    logic [63:0] rd;
    rst = 1'b1; desIn = '0; Tj_Trig = 1'b0;

    // 1-cycle arm with no pattern: legal
    do_reset();
    step(64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(64'd0, 1'b0, 1'b0);
    chk("plan1_max_run", int'(max_run), 1);

    // Legal 2-cycle extension
    do_reset();
    step(PAT, 1'b1, 1'b0);
    step(64'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(64'd0, 1'b0, 1'b0);
    chk("plan2_fired", int'(fired), 1);
    chk("plan2_max_run", int'(max_run), 2);

    // Pattern seen but no extension
    do_reset();
    step(PAT, 1'b1, 1'b0);
    step(64'd0, 1'b0, 1'b0);
    step(64'd0, 1'b0, 1'b0);
    chk("plan3_code", int'(alarm_code), 2);

    // Spurious highs at cycles 50 and 90; code stays from the first
    do_reset();
    for (int c = 0; c < 95; c++) step(64'd0, (c == 0 || c == 50 || c == 90), 1'b0);
    chk("plan4_code", int'(alarm_code), 3);

    // Missing arm then a late high; the run of length 20 saturates max_run
    do_reset();
    for (int c = 0; c < 8; c++) step(64'd0, (c == 5), 1'b0);
    chk("plan5_code", int'(alarm_code), 1);
    for (int c = 0; c < 20; c++) step(64'd1, 1'b1, 1'b0);
    step(64'd1, 1'b0, 1'b0);
    chk("run_saturate", int'(max_run), RUN_MAX);

    // Randomized short sessions
    for (int s = 0; s < 40; s++) begin
      do_reset();
      for (int c = 0; c < 12; c++) begin
        rd = ($urandom_range(0, 1) == 1) ? PAT : {$urandom, $urandom};
        step(rd, (c < 2) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 7) == 0, 1'b0);
      end
    end

    // Hit counter saturation, then reset mid-run restarts the arm check
    do_reset();
    step(PAT, 1'b1, 1'b0);
    step(PAT, 1'b1, 1'b0);
    for (int c = 0; c < 70000; c++) step(PAT, 1'b0, 1'b0);
    chk("hit_saturate", int'(hit_count), HIT_MAX);
    step(PAT, 1'b0, 1'b1);
    chk("mid_reset_hits", int'(hit_count), 0);
    step(64'd0, 1'b0, 1'b0);
    step(64'd0, 1'b0, 1'b0);
    chk("rearm_code", int'(alarm_code), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
